data_bus_unit: RTL and testbench
================================

# data_bus_unit

Bus-cycle sequencer between the 65C02 core's internal data bus and the external memory pins. It accepts one read or write request at a time from the register file and control logic. It runs the address and data phases on the external bus, honouring RDY wait states. On reads, it returns the byte together with a one-cycle load strobe that feeds the accumulator's `db_in` / `instruction_decode_in` path; on writes, it drives register data (e.g. accumulator `db_out`) onto the pins.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, default 255: maximum consecutive RDY-low cycles tolerated in DATA. Used only when `DBU_TIMEOUT_EN` is defined. Range 1..255.

Ports:
- `fclk` input 1: core clock. Single clock domain.
- `resb` input 1: reset, asynchronous, active-low.
- `req` input 1: request valid. Sampled only while `ready`=1.
- `req_we` input 1: 1 = write, 0 = read.
- `req_addr` input 16: target address.
- `req_wdata` input 8: write byte, typically accumulator `db_out`.
- `ready` output 1: unit idle, can accept `req`.
- `rdata` output 8: read byte. Held until the next read completes.
- `done` output 1: one-cycle pulse at end of any transaction.
- `acc_load` output 1: one-cycle pulse, reads only. Drives the accumulator's load strobe; `rdata` is valid in the same cycle.
- `err` output 1: timeout flag, sticky until next accepted `req`. Tied 0 without `DBU_TIMEOUT_EN`.
- `addr_out` output 16: external address.
- `rwb` output 1: external read/not-write.
- `data_out` output 8: external write data.
- `data_oe` output 1: external data drive enable.
- `data_in` input 8: external read data.
- `rdy` input 1: external ready. 0 inserts a wait state.

## Operation
- States: IDLE, ADDR, DATA, RESP.
- **IDLE**: `ready`=1. If `req`=1, capture `req_we`, `req_addr` and `req_wdata` into internal registers, then go to ADDR.
- **ADDR**: drive `addr_out` = captured address and `rwb` = !we. `data_oe`=0. Always go to DATA next cycle.
- **DATA**:
  - Keep `addr_out` and `rwb` unchanged.
  - On writes, `data_out` = captured wdata and `data_oe`=1.
  - If `rdy`=1: on reads, register `data_in` into `rdata`; go to RESP.
  - If `rdy`=0: stay in DATA and hold all outputs.
- **RESP**: `done`=1; `acc_load`=1 if read. Set `rwb`=1 and `data_oe`=0. Return to IDLE.
- `req` outside IDLE is ignored. The requester must hold `req` until `ready`=1.
- Captured request fields are frozen for the whole transaction. Input changes after capture have no effect.
- Reset values: state IDLE, `ready`=1, `rwb`=1, `data_oe`=0, `addr_out`=0, `data_out`=0, `rdata`=0, `done`=0, `acc_load`=0, `err`=0.
- Reset mid-transaction aborts immediately. `data_oe` drops asynchronously, with no `done` and no `acc_load`.

## Timing
- `req` is sampled at edge N. ADDR occupies cycle N+1, DATA occupies cycle N+2 (with `rdy`=1), and RESP occupies N+3. `ready` returns in N+4.
- Zero-wait transaction: 4 cycles from accept to next accept.
- Each RDY-low cycle in DATA adds exactly one cycle.
- `rdata` updates on the edge that leaves DATA, so it is stable throughout RESP.
- All outputs are registered, except `ready`, which is decoded from the state.
- `rwb`=0 only during ADDR and DATA of a write. `data_oe` is never 1 in ADDR, so the pins are not driven before the address is stable.

## Configuration
- `DBU_TIMEOUT_EN` defined:
  - An 8-bit wait counter clears on entry to DATA and increments on each RDY-low cycle.
  - When it reaches `TIMEOUT_CYCLES`, go to RESP with `err`=1 and `done`=1.
  - `acc_load`=0 and `rdata` is unchanged.
  - The counter saturates and never wraps.
- `DBU_TIMEOUT_EN` undefined: no counter. DATA waits indefinitely on `rdy`; `err` is constant 0.

## Structure
- Shared package `core_pkg`:
  - state enum `dbu_state_t` (IDLE, ADDR, DATA, RESP);
  - constants `ADDR_W`=16 and `DATA_W`=8.
- The wait/timeout counter is a sub-module, `dbu_wait_counter` (clear, enable, terminal count output). It is only instantiated under `DBU_TIMEOUT_EN`.

## Test plan
- **Zero-wait read**: read `req_addr`=0x1234 with `data_in`=0xA5 and `rdy`=1. Expect `addr_out`=0x1234 and `rwb`=1 in ADDR and DATA; then `rdata`=0xA5 with `done` and `acc_load` high for one cycle at N+3.
- **Write**: write 0x00FF ← 0x3C. Expect `rwb`=0 in ADDR and DATA, `data_oe`=1 and `data_out`=0x3C in DATA only, `done`=1 and `acc_load`=0 at N+3.
- **Wait states**: read with `rdy` held low for 3 DATA cycles. Expect `done` at N+6 and address held throughout; `req` toggling during the wait is ignored.
- **Timeout** (`DBU_TIMEOUT_EN`, `TIMEOUT_CYCLES`=4): read with `rdy` stuck at 0. Expect `err`=1 and `done`=1 after 4 wait cycles, `acc_load`=0 and `rdata` unchanged; the next `req` clears `err`.
- **Reset mid-write**: assert `resb` low during DATA of a write. Expect `data_oe`=0 and `rwb`=1 with no clock edge, and state IDLE with all reset values after release.
- **Back-to-back**: hold `req` continuously across two reads, 0x0000 then 0x0001. Expect accepts 4 cycles apart, two `acc_load` pulses, and the accumulator loaded with each byte in order.

Source files
------------

// File: rtl/core_pkg.sv
// Shared types and widths for the core's bus-cycle sequencer.
package core_pkg;

    localparam int ADDR_W = 16;
    localparam int DATA_W = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2,
        RESP = 2'd3
    } dbu_state_t;

endpackage

// File: rtl/data_bus_unit_if.sv
// Request/response handshake plus external memory pins of the data bus unit.
interface data_bus_unit_if;
    import core_pkg::*;

    logic              req;
    logic              req_we;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              ready;
    logic [DATA_W-1:0] rdata;
    logic              done;
    logic              acc_load;
    logic              err;
    logic [ADDR_W-1:0] addr_out;
    logic              rwb;
    logic [DATA_W-1:0] data_out;
    logic              data_oe;
    logic [DATA_W-1:0] data_in;
    logic              rdy;

    // master: register file/control logic plus the external memory model
    modport master (
        output req, req_we, req_addr, req_wdata, data_in, rdy,
        input  ready, rdata, done, acc_load, err, addr_out, rwb, data_out, data_oe
    );

    modport slave (
        input  req, req_we, req_addr, req_wdata, data_in, rdy,
        output ready, rdata, done, acc_load, err, addr_out, rwb, data_out, data_oe
    );

endinterface

// File: rtl/dbu_wait_counter.sv
// Saturating 8-bit RDY-low wait counter; tc flags the last tolerated wait cycle.
module dbu_wait_counter #(
    parameter int unsigned TERMINAL = 255
) (
    input  logic fclk,
    input  logic resb,
    input  logic clear,
    input  logic enable,
    output logic tc
);

    logic [7:0] count;

    always_ff @(posedge fclk or negedge resb) begin
        if (!resb) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && count != 8'hFF) begin
            count <= count + 8'd1;
        end
    end

    // Asserted while the current wait cycle is the TERMINAL-th one
    assign tc = (count == 8'(TERMINAL - 1));

endmodule

// File: rtl/data_bus_unit.sv
// 65C02 bus-cycle sequencer: IDLE -> ADDR -> DATA (RDY waits) -> RESP.
// Optional RDY timeout enabled by defining DBU_TIMEOUT_EN.
module data_bus_unit
    import core_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input logic            fclk,
    input logic            resb,
    data_bus_unit_if.slave bus
);

    dbu_state_t        state;
    dbu_state_t        state_nx;
    logic              we_q;
    logic [DATA_W-1:0] wdata_q;
    logic              timeout;

    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
        $error("data_bus_unit: TIMEOUT_CYCLES must be in 1..255");
    end

`ifdef DBU_TIMEOUT_EN
    logic wait_tc;

    dbu_wait_counter #(
        .TERMINAL (TIMEOUT_CYCLES)
    ) u_wait (
        .fclk   (fclk),
        .resb   (resb),
        .clear  (state == ADDR),
        .enable ((state == DATA) && !bus.rdy),
        .tc     (wait_tc)
    );

    assign timeout = (state == DATA) && !bus.rdy && wait_tc;
`else
    assign timeout = 1'b0;
`endif

    always_ff @(posedge fclk or negedge resb) begin
        if (!resb) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (bus.req) state_nx = ADDR;
            ADDR:    state_nx = DATA;
            DATA:    if (bus.rdy || timeout) state_nx = RESP;
            RESP:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    assign bus.ready = (state == IDLE);

    // Request fields frozen at accept; only the pins carry reset values
    always_ff @(posedge fclk) begin
        if (state == IDLE && bus.req) begin
            we_q    <= bus.req_we;
            wdata_q <= bus.req_wdata;
        end
    end

    // Outputs are registered from the transition being taken
    always_ff @(posedge fclk or negedge resb) begin
        if (!resb) begin
            bus.addr_out <= '0;
            bus.rwb      <= 1'b1;
            bus.data_out <= '0;
            bus.data_oe  <= 1'b0;
            bus.rdata    <= '0;
            bus.done     <= 1'b0;
            bus.acc_load <= 1'b0;
            bus.err      <= 1'b0;
        end else begin
            bus.done     <= 1'b0;
            bus.acc_load <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.req) begin
                        bus.addr_out <= bus.req_addr;
                        bus.rwb      <= !bus.req_we;
                        bus.err      <= 1'b0;
                    end
                end
                ADDR: begin
                    if (we_q) begin
                        bus.data_out <= wdata_q;
                        bus.data_oe  <= 1'b1;
                    end
                end
                DATA: begin
                    if (bus.rdy) begin
                        if (!we_q) begin
                            bus.rdata <= bus.data_in;
                        end
                        bus.done     <= 1'b1;
                        bus.acc_load <= !we_q;
                        bus.rwb      <= 1'b1;
                        bus.data_oe  <= 1'b0;
                    end else if (timeout) begin
                        bus.done    <= 1'b1;
                        bus.err     <= 1'b1;
                        bus.rwb     <= 1'b1;
                        bus.data_oe <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_data_bus_unit.sv
// Directed bench for data_bus_unit with a completion scoreboard and accumulator model.
module tb_data_bus_unit;
    import core_pkg::*;

    typedef struct {
        logic [7:0] rdata;
        logic       acc_load;
        logic       err;
    } exp_t;

    logic       fclk = 1'b0;
    logic       resb;
    int         checks = 0;
    int         errors = 0;
    exp_t       sb[$];
    logic [7:0] acc;

    data_bus_unit_if bus ();

    data_bus_unit #(
        .TIMEOUT_CYCLES (4)
    ) dut (
        .fclk (fclk),
        .resb (resb),
        .bus  (bus)
    );

    always #5 fclk = ~fclk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Completion monitor: every done pulse retires one scoreboard entry
    always @(negedge fclk) begin : monitor
        exp_t e;
        if (resb === 1'b1 && bus.done === 1'b1) begin
            chk("sb_pending", 16'(sb.size() != 0), 16'd1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk("sb_rdata", bus.rdata, e.rdata);
                chk("sb_acc_load", bus.acc_load, e.acc_load);
                chk("sb_err", bus.err, e.err);
            end
        end
        if (bus.acc_load === 1'b1) begin
            chk("acc_load_with_done", bus.done, 1'b1);
            acc = bus.rdata;
        end
    end

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: simulation did not reach the end of the sequence");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        resb          = 1'b0;
        bus.req       = 1'b0;
        bus.req_we    = 1'b0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
        bus.data_in   = '0;
        bus.rdy       = 1'b1;
        acc           = '0;

        // Reset values
        repeat (2) @(negedge fclk);
        chk("rst_ready", bus.ready, 1'b1);
        chk("rst_rwb", bus.rwb, 1'b1);
        chk("rst_data_oe", bus.data_oe, 1'b0);
        chk("rst_addr_out", bus.addr_out, 16'h0000);
        chk("rst_data_out", bus.data_out, 8'h00);
        chk("rst_rdata", bus.rdata, 8'h00);
        chk("rst_done", bus.done, 1'b0);
        chk("rst_acc_load", bus.acc_load, 1'b0);
        chk("rst_err", bus.err, 1'b0);
        resb = 1'b1;
        @(negedge fclk);

        // Zero-wait read 0x1234 -> 0xA5
        bus.req = 1'b1; bus.req_we = 1'b0; bus.req_addr = 16'h1234;
        bus.data_in = 8'hA5; bus.rdy = 1'b1;
        sb.push_back('{8'hA5, 1'b1, 1'b0});
        @(negedge fclk);
        chk("rd_addr_ready", bus.ready, 1'b0);
        chk("rd_addr_addr", bus.addr_out, 16'h1234);
        chk("rd_addr_rwb", bus.rwb, 1'b1);
        chk("rd_addr_oe", bus.data_oe, 1'b0);
        bus.req = 1'b0; bus.req_addr = 16'hFFFF;
        @(negedge fclk);
        chk("rd_data_addr", bus.addr_out, 16'h1234);
        chk("rd_data_rwb", bus.rwb, 1'b1);
        chk("rd_data_oe", bus.data_oe, 1'b0);
        chk("rd_data_done", bus.done, 1'b0);
        @(negedge fclk);
        chk("rd_resp_done", bus.done, 1'b1);
        chk("rd_resp_acc_load", bus.acc_load, 1'b1);
        chk("rd_resp_rdata", bus.rdata, 8'hA5);
        @(negedge fclk);
        chk("rd_idle_ready", bus.ready, 1'b1);
        chk("rd_idle_done", bus.done, 1'b0);
        chk("rd_idle_acc_load", bus.acc_load, 1'b0);
        chk("rd_acc", acc, 8'hA5);

        // Write 0x00FF <- 0x3C, request inputs scrambled after accept
        bus.req = 1'b1; bus.req_we = 1'b1; bus.req_addr = 16'h00FF; bus.req_wdata = 8'h3C;
        sb.push_back('{8'hA5, 1'b0, 1'b0});
        @(negedge fclk);
        chk("wr_addr_rwb", bus.rwb, 1'b0);
        chk("wr_addr_oe", bus.data_oe, 1'b0);
        chk("wr_addr_addr", bus.addr_out, 16'h00FF);
        bus.req = 1'b0; bus.req_we = 1'b0; bus.req_wdata = 8'h77;
        @(negedge fclk);
        chk("wr_data_rwb", bus.rwb, 1'b0);
        chk("wr_data_oe", bus.data_oe, 1'b1);
        chk("wr_data_out", bus.data_out, 8'h3C);
        @(negedge fclk);
        chk("wr_resp_done", bus.done, 1'b1);
        chk("wr_resp_acc_load", bus.acc_load, 1'b0);
        chk("wr_resp_oe", bus.data_oe, 1'b0);
        chk("wr_resp_rwb", bus.rwb, 1'b1);
        @(negedge fclk);
        chk("wr_idle_ready", bus.ready, 1'b1);

        // Reset asserted in the DATA phase of a write
        bus.req = 1'b1; bus.req_we = 1'b1; bus.req_addr = 16'h0ABC; bus.req_wdata = 8'h55;
        bus.rdy = 1'b0;
        @(negedge fclk);
        bus.req = 1'b0;
        @(negedge fclk);
        chk("rstw_data_oe", bus.data_oe, 1'b1);
        chk("rstw_data_rwb", bus.rwb, 1'b0);
        #2 resb = 1'b0;
        #1;
        chk("rstw_async_oe", bus.data_oe, 1'b0);
        chk("rstw_async_rwb", bus.rwb, 1'b1);
        chk("rstw_async_addr", bus.addr_out, 16'h0000);
        @(negedge fclk);
        chk("rstw_ready", bus.ready, 1'b1);
        chk("rstw_done", bus.done, 1'b0);
        chk("rstw_acc_load", bus.acc_load, 1'b0);
        chk("rstw_rdata", bus.rdata, 8'h00);
        chk("rstw_data_out", bus.data_out, 8'h00);
        resb = 1'b1; bus.rdy = 1'b1;
        @(negedge fclk);

        // Read 0x4000 with three RDY-low DATA cycles; req toggles meanwhile
        bus.req = 1'b1; bus.req_we = 1'b0; bus.req_addr = 16'h4000;
        bus.rdy = 1'b0; bus.data_in = 8'hEE;
        sb.push_back('{8'h5A, 1'b1, 1'b0});
        @(negedge fclk);
        bus.req_addr = 16'h9999; bus.req_we = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge fclk);
            chk("ws_addr", bus.addr_out, 16'h4000);
            chk("ws_rwb", bus.rwb, 1'b1);
            chk("ws_done", bus.done, 1'b0);
            bus.req = ~bus.req;
        end
        @(negedge fclk);
        chk("ws_last_done", bus.done, 1'b0);
        chk("ws_last_ready", bus.ready, 1'b0);
        bus.req = 1'b0; bus.rdy = 1'b1; bus.data_in = 8'h5A;
        @(negedge fclk);
        chk("ws_resp_done", bus.done, 1'b1);
        chk("ws_resp_rdata", bus.rdata, 8'h5A);
        chk("ws_resp_addr", bus.addr_out, 16'h4000);
        @(negedge fclk);
        chk("ws_idle_ready", bus.ready, 1'b1);
        chk("ws_acc", acc, 8'h5A);

`ifdef DBU_TIMEOUT_EN
        // Read 0x2222 with RDY stuck low: timeout after four wait cycles
        bus.req = 1'b1; bus.req_we = 1'b0; bus.req_addr = 16'h2222;
        bus.rdy = 1'b0; bus.data_in = 8'hEE;
        sb.push_back('{8'h5A, 1'b0, 1'b1});
        @(negedge fclk);
        bus.req = 1'b0;
        repeat (3) @(negedge fclk);
        chk("to_wait_done", bus.done, 1'b0);
        @(negedge fclk);
        chk("to_wait4_done", bus.done, 1'b0);
        chk("to_wait4_ready", bus.ready, 1'b0);
        @(negedge fclk);
        chk("to_resp_done", bus.done, 1'b1);
        chk("to_resp_err", bus.err, 1'b1);
        chk("to_resp_acc_load", bus.acc_load, 1'b0);
        chk("to_resp_rdata", bus.rdata, 8'h5A);
        @(negedge fclk);
        chk("to_idle_err_sticky", bus.err, 1'b1);
        chk("to_idle_ready", bus.ready, 1'b1);
        bus.rdy = 1'b1;
`endif

        // Back-to-back reads 0x0000 -> 0x11, 0x0001 -> 0x22 with req held high
        bus.req = 1'b1; bus.req_we = 1'b0; bus.req_addr = 16'h0000; bus.data_in = 8'h11;
        sb.push_back('{8'h11, 1'b1, 1'b0});
        sb.push_back('{8'h22, 1'b1, 1'b0});
        @(negedge fclk);
        chk("b2b_a_addr", bus.addr_out, 16'h0000);
        chk("b2b_a_err_clr", bus.err, 1'b0);
        chk("b2b_a_ready", bus.ready, 1'b0);
        bus.req_addr = 16'h0001;
        @(negedge fclk);
        chk("b2b_a_data_ready", bus.ready, 1'b0);
        @(negedge fclk);
        chk("b2b_a_acc_load", bus.acc_load, 1'b1);
        chk("b2b_a_rdata", bus.rdata, 8'h11);
        chk("b2b_a_resp_ready", bus.ready, 1'b0);
        bus.data_in = 8'h22;
        @(negedge fclk);
        chk("b2b_idle_ready", bus.ready, 1'b1);
        chk("b2b_acc_first", acc, 8'h11);
        @(negedge fclk);
        chk("b2b_b_addr", bus.addr_out, 16'h0001);
        chk("b2b_b_ready", bus.ready, 1'b0);
        bus.req = 1'b0;
        @(negedge fclk);
        @(negedge fclk);
        chk("b2b_b_acc_load", bus.acc_load, 1'b1);
        chk("b2b_b_rdata", bus.rdata, 8'h22);
        @(negedge fclk);
        chk("b2b_acc_second", acc, 8'h22);
        chk("b2b_end_ready", bus.ready, 1'b1);
        chk("sb_drained", 16'(sb.size()), 16'd0);

        repeat (2) @(negedge fclk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
